// File: rtl/ibex_pkg.sv
// ============================================================================
// Module      : ibex_pkg
// Description : Shared types and constants for the instruction aligner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ibex_pkg;

    typedef enum logic [2:0] {
        ALN_IDLE    = 3'd0,
        ALN_ALIGNED = 3'd1,
        ALN_RES     = 3'd2,
        ALN_SKIP    = 3'd3,
        ALN_ERR     = 3'd4
    } aligner_state_e;

    localparam logic [31:0] HALFWORD_OFFSET = 32'd2;

endpackage

`default_nettype wire

// File: rtl/ibex_instr_aligner.sv
// ============================================================================
// Module      : ibex_instr_aligner
// Description : Turns 32-bit fetch words into one (possibly compressed or
//               word-straddling) instruction per handshake. Optional
//               straddle perf pulse enabled by IBEX_ALIGNER_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_instr_aligner
    import ibex_pkg::*;
#(
    parameter bit ResetAll = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_addr_i,
    input  logic        fetch_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_addr_o,
    output logic        out_is_compressed_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o,
    output logic        perf_straddle_o
);

    aligner_state_e r_state;
    aligner_state_e w_state_d;

    logic [15:0] r_res;
    logic [31:0] r_res_addr;
    logic        r_res_err;

    logic        w_res_load;
    logic [15:0] w_res_d;
    logic        w_res_err_d;
    logic        w_addr_load;
    logic [31:0] w_res_addr_d;

    logic [31:0] w_word_addr;
    logic        w_res_compressed;
    logic        w_fetch_compressed;
    logic        w_handshake;
    logic        w_straddle;
    logic        w_fetch_err;

    assign w_word_addr        = {fetch_addr_i[31:2], 2'b00};
    assign w_res_compressed   = (r_res[1:0] != 2'b11);
    assign w_fetch_compressed = (fetch_rdata_i[1:0] != 2'b11);
    assign w_fetch_err        = fetch_valid_i & fetch_err_i;
    assign w_handshake        = out_valid_o & out_ready_i;
    assign w_straddle         = (r_state == ALN_RES) & ~w_res_compressed;

    // State register: control state is always reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ALN_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state and residual update
    always_comb begin
        w_state_d    = r_state;
        w_res_load   = 1'b0;
        w_res_d      = fetch_rdata_i[31:16];
        w_res_err_d  = 1'b0;
        w_addr_load  = 1'b0;
        w_res_addr_d = w_word_addr + HALFWORD_OFFSET;
        if (branch_i) begin
            w_state_d    = branch_addr_i[1] ? ALN_SKIP : ALN_ALIGNED;
            w_addr_load  = 1'b1;
            w_res_addr_d = {branch_addr_i[31:1], 1'b0};
        end else begin
            case (r_state)
                ALN_ALIGNED: begin
                    if (w_handshake) begin
                        if (w_fetch_err) begin
                            w_state_d = ALN_ERR;
                        end else if (w_fetch_compressed) begin
                            w_state_d   = ALN_RES;
                            w_res_load  = 1'b1;
                            w_addr_load = 1'b1;
                        end
                    end
                end
                ALN_RES: begin
                    if (w_handshake) begin
                        if (out_err_o) begin
                            w_state_d = ALN_ERR;
                        end else if (w_res_compressed) begin
                            w_state_d = ALN_ALIGNED;
                        end else begin
                            w_res_load  = 1'b1;
                            w_res_err_d = w_fetch_err;
                            w_addr_load = 1'b1;
                        end
                    end
                end
                ALN_SKIP: begin
                    // Lower half precedes the target; keep only the upper half
                    if (fetch_valid_i) begin
                        w_state_d   = ALN_RES;
                        w_res_load  = 1'b1;
                        w_res_err_d = fetch_err_i;
                    end
                end
                default: w_state_d = r_state;
            endcase
        end
    end

    // Output decode
    always_comb begin
        out_valid_o         = 1'b0;
        fetch_ready_o       = 1'b0;
        out_instr_o         = 32'h0;
        out_addr_o          = r_res_addr;
        out_is_compressed_o = 1'b0;
        out_err_o           = 1'b0;
        out_err_plus2_o     = 1'b0;
        if (branch_i) begin
            fetch_ready_o = 1'b1;
        end else begin
            case (r_state)
                ALN_ALIGNED: begin
                    out_valid_o   = fetch_valid_i;
                    fetch_ready_o = out_ready_i;
                    out_addr_o    = w_word_addr;
                    if (fetch_err_i) begin
                        out_err_o = 1'b1;
                    end else if (w_fetch_compressed) begin
                        out_instr_o         = {16'h0, fetch_rdata_i[15:0]};
                        out_is_compressed_o = 1'b1;
                    end else begin
                        out_instr_o = fetch_rdata_i;
                    end
                end
                ALN_RES: begin
                    if (w_res_compressed) begin
                        out_valid_o         = 1'b1;
                        out_instr_o         = {16'h0, r_res};
                        out_is_compressed_o = 1'b1;
                        out_err_o           = r_res_err;
                    end else begin
                        out_valid_o     = fetch_valid_i | r_res_err;
                        fetch_ready_o   = out_ready_i;
                        out_instr_o     = {fetch_rdata_i[15:0], r_res};
                        out_err_o       = r_res_err | w_fetch_err;
                        out_err_plus2_o = w_fetch_err & ~r_res_err;
                    end
                end
                ALN_IDLE, ALN_SKIP, ALN_ERR: fetch_ready_o = 1'b1;
                default:                     fetch_ready_o = 1'b1;
            endcase
        end
    end

    generate
        if (ResetAll) begin : g_data_reset
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_res      <= 16'h0;
                    r_res_err  <= 1'b0;
                    r_res_addr <= 32'h0;
                end else begin
                    if (w_res_load) begin
                        r_res     <= w_res_d;
                        r_res_err <= w_res_err_d;
                    end
                    if (w_addr_load) begin
                        r_res_addr <= w_res_addr_d;
                    end
                end
            end
        end else begin : g_data_noreset
            always_ff @(posedge clk_i) begin
                if (w_res_load) begin
                    r_res     <= w_res_d;
                    r_res_err <= w_res_err_d;
                end
                if (w_addr_load) begin
                    r_res_addr <= w_res_addr_d;
                end
            end
        end
    endgenerate

`ifdef IBEX_ALIGNER_PERF_EN
    assign perf_straddle_o = ~branch_i & w_straddle & w_handshake;
`else
    assign perf_straddle_o = 1'b0;
    logic w_unused_perf;
    assign w_unused_perf = w_straddle;
`endif

    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{branch_addr_i[0], fetch_addr_i[1:0]};

`ifndef SYNTHESIS
    logic r_prev_valid;
    logic r_prev_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prev_valid <= 1'b0;
            r_prev_ready <= 1'b0;
        end else begin
            r_prev_valid <= out_valid_o;
            r_prev_ready <= out_ready_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!((r_state == ALN_RES) && w_res_compressed && !branch_i && fetch_ready_o));
            assert (!(r_prev_valid && !r_prev_ready && !branch_i && !out_valid_o));
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ibex_instr_aligner.sv
// ============================================================================
// Module      : tb_ibex_instr_aligner
// Description : Directed bench with a halfword-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibex_instr_aligner;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i = 32'h0;
    logic [31:0] fetch_addr_i = 32'h0;
    logic        fetch_err_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_instr_o;
    logic [31:0] out_addr_o;
    logic        out_is_compressed_o;
    logic        out_err_o;
    logic        out_err_plus2_o;
    logic        perf_straddle_o;

    ibex_instr_aligner dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .branch_i            (branch_i),
        .branch_addr_i       (branch_addr_i),
        .fetch_valid_i       (fetch_valid_i),
        .fetch_ready_o       (fetch_ready_o),
        .fetch_rdata_i       (fetch_rdata_i),
        .fetch_addr_i        (fetch_addr_i),
        .fetch_err_i         (fetch_err_i),
        .out_valid_o         (out_valid_o),
        .out_ready_i         (out_ready_i),
        .out_instr_o         (out_instr_o),
        .out_addr_o          (out_addr_o),
        .out_is_compressed_o (out_is_compressed_o),
        .out_err_o           (out_err_o),
        .out_err_plus2_o     (out_err_plus2_o),
        .perf_straddle_o     (perf_straddle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] hw;
        logic [31:0] addr;
        logic        err;
    } hw_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } word_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        comp;
        logic        err;
        logic        plus2;
        int          cyc;
    } rec_t;

    hw_t   hq[$];
    word_t src[$];
    rec_t  log_q[$];
    bit    m_active = 1'b0;
    bit    m_skip = 1'b0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    perf_cnt = 0;
    int    cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] instr,
                           input logic [31:0] addr);
        if (idx >= log_q.size()) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no instruction #%0d, expected 0x%08h @0x%08h", name, idx, instr, addr);
        end else begin
            chk({name, "_instr"}, log_q[idx].instr, instr);
            chk({name, "_addr"}, log_q[idx].addr, addr);
        end
    endtask

    function automatic word_t mkw(input logic [31:0] a, input logic [31:0] d, input logic e);
        word_t w;
        w.addr = a;
        w.data = d;
        w.err  = e;
        return w;
    endfunction

    // One clock cycle: drive, predict from the halfword stream, compare, advance.
    task automatic step(input bit br, input logic [31:0] br_addr, input bit ordy);
        hw_t         av[$];
        hw_t         h0;
        bit          e_valid, e_ready, chk_ready, chk_instr, e_comp, e_err, e_p2, e_perf;
        bit          uses_word, straddle;
        int          n;
        logic [31:0] e_instr, e_addr, wa;
        @(negedge clk_i);
        branch_i      = br;
        branch_addr_i = br_addr;
        out_ready_i   = ordy;
        if (src.size() > 0) begin
            fetch_valid_i = 1'b1;
            fetch_addr_i  = src[0].addr;
            fetch_rdata_i = src[0].data;
            fetch_err_i   = src[0].err;
        end else begin
            fetch_valid_i = 1'b0;
            fetch_addr_i  = 32'h0;
            fetch_rdata_i = 32'h0;
            fetch_err_i   = 1'b0;
        end
        #2;
        e_valid = 0; e_ready = 1; chk_ready = 1; chk_instr = 1; e_comp = 0; e_err = 0;
        e_p2 = 0; e_perf = 0; uses_word = 0; straddle = 0; n = 0; e_instr = 0; e_addr = 0;
        wa = {fetch_addr_i[31:2], 2'b00};
        av = hq;
        if (!rst_ni || br || !m_active) begin
            chk_ready = 1;
        end else if (m_skip) begin
            chk_ready = fetch_valid_i;
        end else begin
            if (fetch_valid_i) begin
                av.push_back('{hw: fetch_rdata_i[15:0], addr: wa, err: fetch_err_i});
                av.push_back('{hw: fetch_rdata_i[31:16], addr: wa + 32'd2, err: fetch_err_i});
            end
            chk_ready = fetch_valid_i;
            e_ready   = 0;
            if (av.size() > 0) begin
                h0 = av[0];
                if (hq.size() == 0 && h0.err) begin
                    e_valid = 1; e_err = 1; e_addr = h0.addr; n = 2; uses_word = 1;
                end else if (h0.hw[1:0] != 2'b11) begin
                    e_valid = 1; e_instr = {16'h0, h0.hw}; e_comp = 1; e_err = h0.err;
                    e_addr = h0.addr; n = 1; uses_word = (hq.size() == 0);
                end else if (av.size() >= 2) begin
                    e_valid = 1; e_instr = {av[1].hw, h0.hw}; e_err = h0.err | av[1].err;
                    e_p2 = av[1].err & ~h0.err; e_addr = h0.addr; n = 2;
                    uses_word = (hq.size() < 2); straddle = (hq.size() == 1);
                end else if (h0.err) begin
                    e_valid = 1; e_err = 1; e_addr = h0.addr; chk_instr = 0; n = 1; straddle = 1;
                end
                if (uses_word) e_ready = ordy;
            end
        end
`ifdef IBEX_ALIGNER_PERF_EN
        e_perf = straddle & e_valid & ordy;
`endif
        chk("out_valid", {31'h0, out_valid_o}, {31'h0, e_valid});
        if (chk_ready) chk("fetch_ready", {31'h0, fetch_ready_o}, {31'h0, e_ready});
        if (e_valid) begin
            chk("out_addr", out_addr_o, e_addr);
            chk("out_err", {31'h0, out_err_o}, {31'h0, e_err});
            chk("out_err_plus2", {31'h0, out_err_plus2_o}, {31'h0, e_p2});
            chk("out_is_compressed", {31'h0, out_is_compressed_o}, {31'h0, e_comp});
            if (chk_instr) chk("out_instr", out_instr_o, e_instr);
        end
        chk("perf_straddle", {31'h0, perf_straddle_o}, {31'h0, e_perf});
        if (!rst_ni) begin
            m_active = 0;
            hq.delete();
        end else if (br) begin
            m_active = 1;
            m_skip   = br_addr[1];
            hq.delete();
        end else if (m_active && m_skip) begin
            if (fetch_valid_i) begin
                hq.push_back('{hw: fetch_rdata_i[31:16], addr: wa + 32'd2, err: fetch_err_i});
                m_skip = 0;
            end
        end else if (m_active && e_valid && ordy) begin
            if (e_err) begin
                m_active = 0;
                hq.delete();
            end else begin
                if (uses_word) hq = av;
                repeat (n) void'(hq.pop_front());
            end
        end
        if (out_valid_o && out_ready_i)
            log_q.push_back('{instr: out_instr_o, addr: out_addr_o, comp: out_is_compressed_o,
                              err: out_err_o, plus2: out_err_plus2_o, cyc: cyc});
        if (perf_straddle_o) perf_cnt++;
        if (fetch_valid_i && fetch_ready_o && src.size() > 0) void'(src.pop_front());
        cyc++;
    endtask

    initial begin
        int lb;
        int c0;
        int p0;
        // Reset and idle
        repeat (3) step(0, 32'h0, 1);
        chk("reset_valid", {31'h0, out_valid_o}, 32'h0);
        chk("reset_fetch_ready", {31'h0, fetch_ready_o}, 32'h1);
        rst_ni = 1'b1;
        src.push_back(mkw(32'h40, 32'h00000513, 1'b0));
        repeat (2) step(0, 32'h0, 1);
        chk("idle_no_output", log_q.size(), 32'd0);

        // Aligned 32-bit followed by two compressed halves
        src.delete();
        lb = log_q.size();
        step(1, 32'h80, 1);
        src.push_back(mkw(32'h80, 32'h00000513, 1'b0));
        src.push_back(mkw(32'h84, 32'h45014505, 1'b0));
        repeat (5) step(0, 32'h0, 1);
        chk_log("t1_i0", lb, 32'h00000513, 32'h80);
        chk_log("t1_i1", lb + 1, 32'h00004505, 32'h84);
        chk_log("t1_i2", lb + 2, 32'h00004501, 32'h86);

        // Branch to halfword target: straddle with one bubble
        lb = log_q.size();
        p0 = perf_cnt;
        c0 = cyc;
        step(1, 32'h102, 1);
        src.push_back(mkw(32'h100, 32'h05131234, 1'b0));
        src.push_back(mkw(32'h104, 32'h00010000, 1'b0));
        repeat (5) step(0, 32'h0, 1);
        chk_log("t2_i0", lb, 32'h00000513, 32'h102);
        chk_log("t2_i1", lb + 1, 32'h00000001, 32'h106);
        if (log_q.size() > lb) chk("t2_latency", log_q[lb].cyc - c0, 32'd2);
`ifdef IBEX_ALIGNER_PERF_EN
        chk("t2_perf_pulses", perf_cnt - p0, 32'd1);
`else
        chk("t2_perf_pulses", perf_cnt - p0, 32'd0);
`endif

        // Error on the second word of a straddling instruction
        lb = log_q.size();
        step(1, 32'h102, 1);
        src.push_back(mkw(32'h100, 32'h05131234, 1'b0));
        src.push_back(mkw(32'h104, 32'h00030000, 1'b0));
        src.push_back(mkw(32'h108, 32'hBEEF0001, 1'b1));
        src.push_back(mkw(32'h10C, 32'h00000513, 1'b0));
        repeat (8) step(0, 32'h0, 1);
        chk_log("t3_i0", lb, 32'h00000513, 32'h102);
        chk_log("t3_err", lb + 1, 32'h00010003, 32'h106);
        if (log_q.size() > lb + 1) begin
            chk("t3_err_flag", {31'h0, log_q[lb + 1].err}, 32'h1);
            chk("t3_err_plus2", {31'h0, log_q[lb + 1].plus2}, 32'h1);
        end
        chk("t3_no_more_output", log_q.size(), lb + 2);

        // Stall while a compressed residual is held
        src.delete();
        step(1, 32'h200, 1);
        src.push_back(mkw(32'h200, 32'h45014505, 1'b0));
        src.push_back(mkw(32'h204, 32'h00000513, 1'b0));
        step(0, 32'h0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 32'h0, 0);
            chk("t4_fetch_ready", {31'h0, fetch_ready_o}, 32'h0);
            chk("t4_instr_stable", out_instr_o, 32'h00004501);
        end
        step(0, 32'h0, 1);

        // Branch collides with a valid handshake on word 0x204
        lb = log_q.size();
        step(1, 32'h300, 1);
        chk("t5_branch_valid", {31'h0, out_valid_o}, 32'h0);
        src.delete();
        src.push_back(mkw(32'h300, 32'h00100093, 1'b0));
        repeat (3) step(0, 32'h0, 1);
        chk_log("t5_target", lb, 32'h00100093, 32'h300);
        chk("t5_count", log_q.size(), lb + 1);

        // Target at the top of the address space
        lb = log_q.size();
        step(1, 32'hFFFF_FFFE, 1);
        src.push_back(mkw(32'hFFFF_FFFC, 32'h00010000, 1'b0));
        src.push_back(mkw(32'h0000_0000, 32'h00000513, 1'b0));
        repeat (5) step(0, 32'h0, 1);
        chk_log("t6_top", lb, 32'h00000001, 32'hFFFF_FFFE);
        chk_log("t6_wrap", lb + 1, 32'h00000513, 32'h0);

        // Asynchronous reset while holding a residual
        step(1, 32'h400, 1);
        src.push_back(mkw(32'h400, 32'h45014505, 1'b0));
        src.push_back(mkw(32'h404, 32'h00000513, 1'b0));
        step(0, 32'h0, 1);
        step(0, 32'h0, 0);
        chk("t7_valid_before", {31'h0, out_valid_o}, 32'h1);
        lb = log_q.size();
        rst_ni = 1'b0;
        #1;
        chk("t7_async_valid", {31'h0, out_valid_o}, 32'h0);
        chk("t7_async_ready", {31'h0, fetch_ready_o}, 32'h1);
        m_active = 0;
        hq.delete();
        repeat (2) step(0, 32'h0, 1);
        rst_ni = 1'b1;
        repeat (3) step(0, 32'h0, 1);
        chk("t7_no_output", log_q.size(), lb);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
